// File: rtl/atm_pkg.sv
// atm_pkg: opcodes, response status codes and FSM state encoding shared by the ATM responder and controller.
package atm_pkg;
  typedef logic [1:0] op_t;
  typedef logic [1:0] status_t;
  localparam op_t OP_PIN = 2'b00;
  localparam op_t OP_BAL = 2'b01;
  localparam op_t OP_DEP = 2'b10;
  localparam op_t OP_WD  = 2'b11;
  localparam status_t ST_OK     = 2'b00;
  localparam status_t ST_BADPIN = 2'b01;
  localparam status_t ST_REJ    = 2'b10;
  localparam status_t ST_DENY   = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
endpackage

// File: rtl/atm_bank_responder_if.sv
// atm_bank_responder_if: request/response handshake between the ATM (master) and the bank responder (slave).
interface atm_bank_responder_if;
  import atm_pkg::*;
  logic        req_valid;
  logic        req_ready;
  op_t         req_op;
  logic [3:0]  req_pin;
  logic [31:0] req_amount;
  logic        rsp_valid;
  logic        rsp_ready;
  status_t     rsp_status;
  logic [31:0] rsp_balance;
  logic        session_end;
  logic        locked;
  modport master (
    output req_valid, req_op, req_pin, req_amount, rsp_ready, session_end,
    input  req_ready, rsp_valid, rsp_status, rsp_balance, locked
  );
  modport slave (
    input  req_valid, req_op, req_pin, req_amount, rsp_ready, session_end,
    output req_ready, rsp_valid, rsp_status, rsp_balance, locked
  );
endinterface

// File: rtl/atm_pin_checker.sv
// atm_pin_checker: PIN compare, authentication flag and, with ATM_LOCKOUT_EN, the bad-PIN counter and lockout.
module atm_pin_checker #(
  parameter logic [3:0] CORRECT_PIN = 4'b1010,
  parameter int         MAX_TRIES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       check,
  input  logic       session_end,
  input  logic [3:0] pin,
  output logic       match,
  output logic       auth,
  output logic       locked
);
  logic auth_q, auth_d;
  assign match  = pin == CORRECT_PIN;
  // a card ejected during evaluation already counts as logged out
  assign auth   = auth_q & ~session_end;
  assign auth_d = session_end ? 1'b0 : check ? match & ~locked : auth_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) auth_q <= 1'b0;
    else       auth_q <= auth_d;
`ifdef ATM_LOCKOUT_EN
  logic [3:0] fails_q, fails_d;
  logic       locked_q, locked_d;
  assign fails_d  = check & ~locked_q ? (match ? 4'd0 : fails_q + 4'd1) : fails_q;
  assign locked_d = locked_q | (check & ~match & fails_d == 4'(MAX_TRIES));
  assign locked   = locked_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fails_q  <= 4'd0;
      locked_q <= 1'b0;
    end else begin
      fails_q  <= fails_d;
      locked_q <= locked_d;
    end
`else
  // never locks for any legal MAX_TRIES (1..15)
  assign locked = MAX_TRIES == 0;
`endif
endmodule

// File: rtl/atm_bank_responder.sv
// atm_bank_responder: bank-side account engine (PIN, balance, deposit, withdraw) behind a valid/ready handshake.
// Define ATM_LOCKOUT_EN to lock the account after MAX_TRIES consecutive bad PINs.
module atm_bank_responder import atm_pkg::*; #(
  parameter logic [31:0] INIT_BALANCE = 32'h000F4240,
  parameter logic [3:0]  CORRECT_PIN  = 4'b1010,
  parameter int          MAX_TRIES    = 3
) (
  input logic clk,
  input logic reset,
  atm_bank_responder_if.slave bus
);
  logic [1:0]  state_q, state_d;
  op_t         op_q;
  logic [3:0]  pin_q;
  logic [31:0] amt_q, bal_q, bal_d;
  status_t     status_q, status_d;
  logic        match, auth, locked;
  logic [32:0] sum;
  assign sum = {1'b0, bal_q} + {1'b0, amt_q};
  atm_pin_checker #(.CORRECT_PIN(CORRECT_PIN), .MAX_TRIES(MAX_TRIES)) u_pin (
    .clk         (clk),
    .reset       (reset),
    .check       (state_q == S_EXEC && op_q == OP_PIN),
    .session_end (bus.session_end),
    .pin         (pin_q),
    .match       (match),
    .auth        (auth),
    .locked      (locked)
  );
  always_comb begin
    state_d  = state_q == S_IDLE ? (bus.req_valid ? S_EXEC : S_IDLE) :
               state_q == S_EXEC ? S_RESP :
               (state_q == S_RESP && !bus.rsp_ready) ? S_RESP : S_IDLE;
    status_d = locked              ? ST_DENY :
               op_q == OP_PIN      ? (match ? ST_OK : ST_BADPIN) :
               !auth               ? ST_DENY :
               op_q == OP_DEP      ? (sum[32] ? ST_REJ : ST_OK) :
               op_q == OP_WD       ? (amt_q <= bal_q ? ST_OK : ST_REJ) : ST_OK;
    bal_d    = status_d != ST_OK   ? bal_q :
               op_q == OP_DEP      ? sum[31:0] :
               op_q == OP_WD       ? bal_q - amt_q : bal_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_PIN;
      pin_q    <= 4'd0;
      amt_q    <= 32'd0;
      bal_q    <= INIT_BALANCE;
      status_q <= ST_OK;
    end else begin
      state_q <= state_d;
      if (bus.req_valid && bus.req_ready) begin
        op_q  <= bus.req_op;
        pin_q <= bus.req_pin;
        amt_q <= bus.req_amount;
      end
      if (state_q == S_EXEC) begin
        bal_q    <= bal_d;
        status_q <= status_d;
      end
    end
  // the balance register only moves on the EXEC->RESP edge, so it doubles as the response balance
  assign bus.req_ready   = state_q == S_IDLE;
  assign bus.rsp_valid   = state_q == S_RESP;
  assign bus.rsp_status  = status_q;
  assign bus.rsp_balance = bal_q;
  assign bus.locked      = locked;
endmodule
